// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes and the per-lane
// decoded bundle carried through the stage registers.
package decode_pkg;

    localparam int DEC_XLEN = 32;

    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_NONE     = 4'b0000;
    localparam logic [3:0] ALU_OR       = 4'b0001;
    localparam logic [3:0] ALU_ADD      = 4'b0010;
    localparam logic [3:0] ALU_XOR      = 4'b0011;
    localparam logic [3:0] ALU_AND      = 4'b0100;
    localparam logic [3:0] ALU_SUB      = 4'b0101;
    localparam logic [3:0] ALU_SLL      = 4'b0110;
    localparam logic [3:0] ALU_SRL      = 4'b0111;
    localparam logic [3:0] ALU_SLT      = 4'b1000;
    localparam logic [3:0] ALU_SLTU     = 4'b1001;
    localparam logic [3:0] ALU_SRA      = 4'b1011;
    localparam logic [3:0] ALU_PASS_IMM = 4'b1111;

    typedef struct packed {
        logic                valid;
        logic                illegal;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          func3;
        logic [DEC_XLEN-1:0] imm;
        logic                load_store;
        logic                alu_src;
        logic                reg_write;
        logic                bms;
        logic [3:0]          alu_control;
    } lane_t;

    // func3 to ALU op; alt selects SUB/SRA where the encoding has an alternate form
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder producing one lane bundle.
module decode_lane
    import decode_pkg::*;
(
    input  logic [DEC_XLEN-1:0] instr,
    input  logic                lane_valid,
    output lane_t               dec
);

    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [DEC_XLEN-1:0] imm_i;
    logic [DEC_XLEN-1:0] imm_s;
    logic [DEC_XLEN-1:0] imm_u;
    logic [DEC_XLEN-1:0] imm_sh;
    logic                f7_zero;
    logic                f7_alt;
    logic                legal;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign func3   = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign func7   = instr[31:25];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_sh  = {27'b0, instr[24:20]};
    assign f7_zero = (func7 == 7'h00);
    assign f7_alt  = (func7 == 7'h20);

    // Field extraction and control generation; illegal encodings collapse to a bare flag
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        if (lane_valid) begin
            dec.valid = 1'b1;
            case (opcode)
                OP_NOP: begin
                end
                OP_RTYPE: begin
                    legal           = f7_zero || (f7_alt && (func3 == 3'b000 || func3 == 3'b101));
                    dec.opcode      = opcode;
                    dec.rd          = rd;
                    dec.rs1         = rs1;
                    dec.rs2         = rs2;
                    dec.func3       = func3;
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_from_f3(func3, f7_alt);
                end
                OP_ITYPE: begin
                    dec.opcode    = opcode;
                    dec.rd        = rd;
                    dec.rs1       = rs1;
                    dec.func3     = func3;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    if (func3 == 3'b001 || func3 == 3'b101) begin
                        legal           = f7_zero || (f7_alt && func3 == 3'b101);
                        dec.imm         = imm_sh;
                        dec.alu_control = alu_from_f3(func3, f7_alt);
                    end else begin
                        dec.imm         = imm_i;
                        dec.alu_control = alu_from_f3(func3, 1'b0);
                    end
                end
                OP_LOAD: begin
                    legal           = (func3 == 3'b000) || (func3 == 3'b010);
                    dec.opcode      = opcode;
                    dec.rd          = rd;
                    dec.rs1         = rs1;
                    dec.func3       = func3;
                    dec.imm         = imm_i;
                    dec.alu_src     = 1'b1;
                    dec.load_store  = 1'b1;
                    dec.reg_write   = 1'b1;
                    dec.bms         = (func3 == 3'b000);
                    dec.alu_control = ALU_ADD;
                end
                OP_STORE: begin
                    legal           = (func3 == 3'b000) || (func3 == 3'b010);
                    dec.opcode      = opcode;
                    dec.rs1         = rs1;
                    dec.rs2         = rs2;
                    dec.func3       = func3;
                    dec.imm         = imm_s;
                    dec.alu_src     = 1'b1;
                    dec.load_store  = 1'b1;
                    dec.bms         = (func3 == 3'b000);
                    dec.alu_control = ALU_ADD;
                end
                OP_LUI: begin
                    dec.opcode      = opcode;
                    dec.rd          = rd;
                    dec.imm         = imm_u;
                    dec.reg_write   = 1'b1;
                    dec.alu_control = ALU_PASS_IMM;
                end
                default: legal = 1'b0;
            endcase
            if (!legal) begin
                dec         = '0;
                dec.valid   = 1'b1;
                dec.illegal = 1'b1;
            end
            if (dec.rd == 5'd0) begin
                dec.reg_write = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_stage_nw.sv
// N-wide decode stage: per-lane decoders feeding a main register with a
// one-group skid register behind a valid/ready handshake.
module decode_stage_nw
    import decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in_instr,
    input  logic [LANES-1:0]      in_lane_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*7-1:0]    out_opcode,
    output logic [LANES*5-1:0]    out_rd,
    output logic [LANES*5-1:0]    out_rs1,
    output logic [LANES*5-1:0]    out_rs2,
    output logic [LANES*3-1:0]    out_func3,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES-1:0]      out_load_store,
    output logic [LANES-1:0]      out_alu_src,
    output logic [LANES-1:0]      out_reg_write,
    output logic [LANES-1:0]      out_bms,
    output logic [LANES-1:0]      out_illegal,
    output logic [LANES*4-1:0]    out_alu_control
);

    lane_t [LANES-1:0] dec_w;
    lane_t [LANES-1:0] m_data_q, m_data_d;
    lane_t [LANES-1:0] s_data_q, s_data_d;
    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic              accept;
    logic              drain;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            decode_lane u_decode_lane (
                .instr      (in_instr[gi*XLEN +: XLEN]),
                .lane_valid (in_lane_valid[gi]),
                .dec        (dec_w[gi])
            );
            assign out_lane_valid[gi]        = m_data_q[gi].valid;
            assign out_opcode[gi*7 +: 7]     = m_data_q[gi].opcode;
            assign out_rd[gi*5 +: 5]         = m_data_q[gi].rd;
            assign out_rs1[gi*5 +: 5]        = m_data_q[gi].rs1;
            assign out_rs2[gi*5 +: 5]        = m_data_q[gi].rs2;
            assign out_func3[gi*3 +: 3]      = m_data_q[gi].func3;
            assign out_imm[gi*XLEN +: XLEN]  = m_data_q[gi].imm;
            assign out_load_store[gi]        = m_data_q[gi].load_store;
            assign out_alu_src[gi]           = m_data_q[gi].alu_src;
            assign out_reg_write[gi]         = m_data_q[gi].reg_write;
            assign out_bms[gi]               = m_data_q[gi].bms;
            assign out_illegal[gi]           = m_data_q[gi].illegal;
            assign out_alu_control[gi*4 +: 4] = m_data_q[gi].alu_control;
        end
    endgenerate

    // The skid slot being empty is exactly the condition for taking another group
    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = m_valid_q && out_ready;

    // Next-state for main/skid slots: drain first, then place an accepted group
    always_comb begin
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_data_d  = '0;
            s_data_d  = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            if (drain) begin
                if (s_valid_q) begin
                    m_data_d  = s_data_q;
                    s_valid_d = 1'b0;
                end else begin
                    m_valid_d = 1'b0;
                end
            end
            if (accept) begin
                if (!m_valid_q || (drain && !s_valid_q)) begin
                    m_data_d  = dec_w;
                    m_valid_d = 1'b1;
                end else begin
                    s_data_d  = dec_w;
                    s_valid_d = 1'b1;
                end
            end
        end
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_q  <= '0;
            s_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

endmodule

// File: doc/decode_stage_nw.md
Name: decode_stage_nw

Overview:
- Parametrised N-wide successor to the single-issue decode register stage.
- Decodes LANES instructions per cycle into per-lane control bundles: RV32I ALU subset, LB/LW/SB/SW, LUI.
- Decoded bundles sit behind a valid/ready handshake with a 2-entry skid buffer, so fetch can stall cleanly.
- Adds flush support and an illegal-instruction flag per lane.

Parameters:
- LANES, 2, instructions decoded per group (1..4).
- XLEN, 32, instruction and immediate width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  discard all held and incoming groups.
- in_valid  in  1  fetch group valid.
- in_ready  out  1  stage can accept a group; registered.
- in_instr  in  LANES*XLEN  instructions; lane i at [i*XLEN +: XLEN].
- in_lane_valid  in  LANES  per-lane valid mask.
- out_valid  out  1  decoded group valid.
- out_ready  in  1  rename/issue accepts the group.
- out_lane_valid  out  LANES  per-lane valid.
- out_opcode  out  LANES*7  opcode.
- out_rd, out_rs1, out_rs2  out  LANES*5 each  register indices.
- out_func3  out  LANES*3  func3.
- out_imm  out  LANES*XLEN  extended immediate.
- out_load_store, out_alu_src, out_reg_write, out_bms, out_illegal  out  LANES each  control flags.
- out_alu_control  out  LANES*4  ALU op.

Behaviour:
- ALU op codes: NONE 0000, OR 0001, ADD 0010, XOR 0011, AND 0100, SUB 0101, SLL 0110, SRL 0111, SLT 1000, SLTU 1001, SRA 1011, PASS_IMM 1111.
- R-type (0110011): func3/func7 select ADD/SUB (func7 0x20), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. reg_write=1, alu_src=0, imm=0.
- I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI use sign-extended imm[31:20]. SLLI/SRLI/SRAI use zero-extended shamt [24:20] and require func7 0x00/0x20. alu_src=1, reg_write=1.
- LOAD (0000011): func3 000 (LB, bms=1) or 010 (LW, bms=0); any other func3 is illegal. ADD, alu_src=1, load_store=1, reg_write=1, sign-extended I imm.
- STORE (0100011): func3 000 (SB, bms=1) or 010 (SW). S imm sign-extended, rd=0, reg_write=0, load_store=1.
- LUI (0110111): imm={instr[31:12],12'b0}, PASS_IMM, rs1=rs2=0.
- Opcode 0000000: NOP. All fields 0, not illegal.
- BMS is always derived from the current instruction's func3, never from a registered value.
- Any other opcode or unsupported func3/func7: illegal=1; rd/rs1/rs2/imm/flags/alu_control forced 0.
- rd==0 with reg_write=1: reg_write forced to 0.
- in_lane_valid[i]=0: lane decoded as NOP, out_lane_valid[i]=0.
- Storage: main register M (drives the outputs) and skid register S, each with its own valid bit.
- in_ready = !S.valid.
- Accept happens when in_valid && in_ready:
  - if M is empty, or M is draining this cycle (out_ready=1) and S is empty: group goes to M;
  - otherwise: group goes to S.
- Drain happens when out_valid && out_ready: S moves to M if S is valid, otherwise M.valid clears.
- Simultaneous accept and drain with S empty: new group loads M in the same edge. No bubble, full throughput.
- Latency: instruction to out_valid is 1 cycle.
- While out_valid=1 && out_ready=0, all out_* hold stable.
- flush=1: M.valid and S.valid clear at the next edge. Any same-cycle accept is dropped (flush wins). in_ready=1 the following cycle.
- Reset (async): M, S, and all out_* go to 0; out_valid=0; in_ready=1 once reset deasserts.
- Reset or flush mid-stall discards the held groups with no partial output.

Decomposition:
- Package decode_pkg holds:
  - opcode constants OP_NOP, OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_LUI;
  - ALU op constants;
  - the decoded-lane struct (opcode, rd, rs1, rs2, func3, imm, flags, alu_control, illegal, valid).
- Sub-module decode_lane: purely combinational single-instruction decoder, instantiated LANES times.
- Top level holds the M/S registers and the handshake.

Test Plan:
- LANES=2, out_ready=1. Lane0 ADD x3,x1,x2 (0x002081B3), lane1 SUB x4,x1,x2 (0x40208233) -> next cycle out_valid=1, alu_control 0010/0101, rd 3/4, reg_write 1/1.
- LB x5,-4(x6) (0xFFC30283) and SW x7,8(x2) (0x00712423) -> lane0 imm 0xFFFFFFFC, bms=1, load_store=1; lane1 imm 8, rd=0, reg_write=0, bms=0.
- Hold out_ready=0 and present 3 consecutive groups -> groups 1 and 2 accepted, in_ready=0 at group 3. Raise out_ready -> groups emerge in order 1, 2, 3 with no loss or duplication, one per cycle.
- Illegal opcode 0x0000007F and LW with func3=011 -> illegal=1, reg_write=0, alu_control=0000; neighbouring lane unaffected.
- flush while M and S are both full, with in_valid=1 on the same cycle -> next cycle out_valid=0, in_ready=1, flushed group never appears.
- Assert reset mid-stall with out_valid=1 -> out_valid and all out_* 0 immediately (async); after deassertion in_ready=1. ADDI x1,x0,5 (0x00500093) then decodes with imm=5, ADD.
